// File: rtl/col_burst_pkg.sv
// Shared types, burst-length codes and the beat-offset rule for the column burst generator.
package col_burst_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic [1:0] BL1 = 2'd0;
  localparam logic [1:0] BL2 = 2'd1;
  localparam logic [1:0] BL4 = 2'd2;
  localparam logic [1:0] BL8 = 2'd3;

  localparam int unsigned OFS_W = 8;

  // Low-order column bits of beat k: wrap-around add (sequential) or XOR (interleaved) within 2^l.
  function automatic logic [OFS_W-1:0] burst_offset(input logic [OFS_W-1:0] start_low,
                                                    input logic [OFS_W-1:0] k,
                                                    input logic             interleaved,
                                                    input logic [1:0]       l);
    logic [OFS_W-1:0] mask;
    mask = (OFS_W'(1) << l) - OFS_W'(1);
    burst_offset = interleaved ? ((start_low ^ k) & mask) : ((start_low + k) & mask);
  endfunction

endpackage

// File: rtl/col_burst_addr_gen_counter.sv
// Beat index tracker: holds the index of the beat on the outputs and flags the final beat.
module burst_beat_counter #(
  parameter int unsigned K_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           adv_i,
  input  logic [1:0]     l_i,
  output logic [K_W-1:0] next_k_c,
  output logic           next_last_c,
  output logic           done_c
);

  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_d;
  logic [K_W-1:0] bl_m1;

  always_comb begin
    bl_m1       = (K_W'(1) << l_i) - K_W'(1);
    next_k_c    = k_q + K_W'(1);
    next_last_c = (next_k_c == bl_m1);
    done_c      = (k_q == bl_m1);
    k_d         = k_q;
    if (clr_i) begin
      k_d = '0;
    end else if (adv_i) begin
      k_d = next_k_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/col_burst_addr_gen.sv
// Column burst address generator: latches a CAS start address and emits one column per clock.
module col_burst_addr_gen
  import col_burst_pkg::*;
#(
  parameter int unsigned COL_ADDR_DEPTH = 8,
  parameter int unsigned MAX_BL_LOG2    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cas,
  input  logic [COL_ADDR_DEPTH-1:0] col_addr_in,
  input  logic [1:0]                burst_len_code,
  input  logic                      burst_type,
  input  logic                      burst_term,
  output logic [COL_ADDR_DEPTH-1:0] col_addr_out,
  output logic                      col_valid,
  output logic                      burst_last,
  output logic                      busy
);

  localparam int unsigned K_W = MAX_BL_LOG2 + 1;

  state_e                    state_q, state_d;
  logic [COL_ADDR_DEPTH-1:0] start_q, start_d;
  logic [1:0]                l_q, l_d;
  logic                      type_q, type_d;
  logic [COL_ADDR_DEPTH-1:0] addr_q, addr_d;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic                      busy_q, busy_d;

  logic [1:0]                l_eff_c;
  logic [COL_ADDR_DEPTH-1:0] lmask_c;
  logic [OFS_W-1:0]          offset_c;
  logic [K_W-1:0]            next_k_c;
  logic                      next_last_c;
  logic                      done_c;
  logic                      adv_c;

  assign adv_c = (state_q == ST_BURST) && !cas;

  burst_beat_counter #(
    .K_W (K_W)
  ) u_beat_counter (
    .clk         (clk),
    .rst_n       (reset),
    .clr_i       (cas),
    .adv_i       (adv_c),
    .l_i         (l_q),
    .next_k_c    (next_k_c),
    .next_last_c (next_last_c),
    .done_c      (done_c)
  );

  // Next-state, start latch and next beat address.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    l_d     = l_q;
    type_d  = type_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    last_d  = 1'b0;

    l_eff_c = (int'(burst_len_code) > int'(MAX_BL_LOG2)) ? 2'(MAX_BL_LOG2) : burst_len_code;

    lmask_c = '0;
    for (int i = 0; i < int'(MAX_BL_LOG2); i++) begin
      if (i < int'(l_q)) lmask_c[i] = 1'b1;
    end
    offset_c = burst_offset(OFS_W'(start_q), OFS_W'(next_k_c), type_q, l_q);

    if (cas) begin
      state_d = ST_BURST;
      start_d = col_addr_in;
      l_d     = l_eff_c;
      type_d  = burst_type;
      addr_d  = col_addr_in;
      valid_d = 1'b1;
      last_d  = (l_eff_c == BL1);
    end else if (state_q == ST_BURST) begin
      if (burst_term || done_c) begin
        state_d = ST_IDLE;
      end else begin
        addr_d  = (start_q & ~lmask_c) | (COL_ADDR_DEPTH'(offset_c) & lmask_c);
        valid_d = 1'b1;
        last_d  = next_last_c;
      end
    end

    busy_d = (state_d == ST_BURST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      l_q     <= '0;
      type_q  <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      l_q     <= l_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign col_addr_out = addr_q;
  assign col_valid    = valid_q;
  assign burst_last   = last_q;
  assign busy         = busy_q;

endmodule
